// File: rtl/mem_port.sv
// rtl/mem_port.sv - valid/ready client adapter for the 1-cycle-latency sync RAM with credit-gated response FIFO
module mem_port #(
  parameter int XLEN      = 32,
  parameter int SIZE      = 256,
  parameter int RSP_DEPTH = 3,
  localparam int ADDR     = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [ADDR-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            mem_write,
  output logic [ADDR-1:0] mem_write_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic [ADDR-1:0] mem_read_addr,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic            rd_pending;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] fifo [RSP_DEPTH];
  logic [CW:0]     credits_used;
  logic            accept;
  logic            push;
  logic            pop;

  // Pointers wrap at RSP_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check, RAM-side request mapping and response presentation.
  // A read in flight reserves a FIFO slot, so the buffer can never overflow;
  // credits depend only on registered state, never on rsp_ready.
  always_comb begin
    credits_used   = {1'b0, count} + {{CW{1'b0}}, rd_pending};
    req_ready      = !rst && (credits_used < (CW + 1)'(RSP_DEPTH));
    accept         = req_valid && req_ready;
    mem_write      = accept && req_write;
    mem_write_addr = req_addr;
    mem_write_data = req_wdata;
    mem_read_addr  = req_addr;
    rsp_valid      = !rst && (count != '0);
    rsp_data       = fifo[rd_ptr];
    push           = rd_pending;
    pop            = rsp_valid && rsp_ready;
  end

  // Control state: read-latency tracker, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      rd_pending <= accept && !req_write;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Response storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo[wr_ptr] <= mem_read_data;
  end

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Initiator-side adapter that drives the team's single-write/single-read synchronous RAM, whose read data is registered with one cycle of latency.
- Presents a valid/ready request channel and a valid/ready read-response channel to a client such as a core load/store unit or a DMA engine.
- Tracks the one-cycle RAM read latency and buffers read data in a small response FIFO, so the client may apply backpressure without losing data.
- Sits between the client and the RAM instance; the `mem_*` ports connect one-to-one to the RAM ports.

Parameters:
- XLEN, 32, data word width in bits.
- SIZE, 256, RAM depth in words; localparam ADDR = $clog2(SIZE).
- RSP_DEPTH, 3, response FIFO depth in entries; must be >= 1. Default 3 sustains one read per cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  client request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR  word address.
- req_wdata  input  XLEN  write data; ignored for reads.
- rsp_valid  output  1  read response valid.
- rsp_ready  input  1  client consumes response when rsp_valid && rsp_ready.
- rsp_data  output  XLEN  read data.
- mem_write  output  1  to RAM write enable.
- mem_write_addr  output  ADDR  to RAM write address.
- mem_write_data  output  XLEN  to RAM write data.
- mem_read_addr  output  ADDR  to RAM read address.
- mem_read_data  input  XLEN  from RAM registered read data.

Behaviour:
- State:
  - rd_pending (1 bit): a read was issued to the RAM last cycle.
  - Response FIFO of RSP_DEPTH entries: rd_ptr, wr_ptr, occupancy count of width $clog2(RSP_DEPTH+1).
- Credit rule:
  - req_ready = !rst && (count + rd_pending < RSP_DEPTH).
  - The same rule gates writes and reads; req_ready never depends on req_valid, req_write or rsp_ready.
  - Invariant: count + rd_pending <= RSP_DEPTH, so the FIFO never overflows.
- Write accept in cycle N:
  - mem_write = 1 combinationally in cycle N.
  - mem_write_addr = req_addr and mem_write_data = req_wdata combinationally.
  - The RAM commits the write at the end of cycle N. No response is produced.
- mem_write is 0 whenever there is no accepted write, including during rst.
- Read path:
  - mem_read_addr = req_addr at all times.
  - A read accepted in cycle N sets rd_pending = 1 for cycle N+1.
  - In cycle N+1, mem_read_data is pushed into the FIFO at the end of that cycle.
  - rsp_valid rises in cycle N+2. Fixed latency is 2 cycles from accept to rsp_valid when the FIFO was empty.
- Response channel:
  - rsp_valid = (count != 0). rsp_data = FIFO head, registered.
  - While rsp_valid && !rsp_ready, rsp_data and rsp_valid hold stable.
  - Responses are returned strictly in request order.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance modulo RSP_DEPTH. Pointers wrap at RSP_DEPTH, which need not be a power of 2.
- A pop frees its credit in the following cycle only. There is no combinational rsp_ready -> req_ready path.
- Ordering against the RAM's nonblocking semantics:
  - A write in cycle N followed by a read of the same address in N+1 returns the new data.
  - A write and a read are never issued in the same cycle, because only one request is accepted per cycle.
- Reset, any cycle:
  - rd_pending, count, rd_ptr and wr_ptr go to 0.
  - rsp_valid = 0 and req_ready = 0 while rst is high.
  - An in-flight read or buffered responses at reset are discarded and never presented.
  - A write accepted in the same cycle as rst does not occur, because req_ready = 0.
  - req_ready = 1 in the first cycle after rst deasserts.
- Throughput with rsp_ready held at 1 and RSP_DEPTH >= 3: one request accepted per cycle indefinitely.
- Throughput with RSP_DEPTH = 2: at most 2 reads per 3 cycles.

Test Plan:
- Write 0xDEADBEEF to address 5 in cycle N, then read 5 in cycle N+1 -> rsp_valid in cycle N+3 with rsp_data = 0xDEADBEEF; mem_write pulses for exactly one cycle.
- Preload address a with a*3+1 for a = 0..7, then issue back-to-back reads of 0..7 with rsp_ready = 1 -> req_ready stays 1 throughout; 8 consecutive responses 1, 4, 7, ..., 22, in order.
- With rsp_ready = 0, stream reads of addresses 0..7 -> exactly 3 are accepted and req_ready drops. Then raise rsp_ready -> responses for 0, 1, 2 drain in order, and req_ready reasserts the cycle after the first pop.
- Full buffer with rsp_ready = 0, then present a write to address 9 -> mem_write stays 0 and the RAM is unchanged. After one pop the write is accepted; a subsequent read of 9 returns the written value.
- Two reads outstanding (one buffered, one pending), then assert rst for one cycle -> rsp_valid = 0 from the next cycle and no stale response ever appears; req_ready = 1 in the first cycle after release.
- Read with rsp_ready toggling 0/1 every cycle -> rsp_data never changes while rsp_valid && !rsp_ready; no response is lost or duplicated over 20 reads.
